ifetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the single-cycle MIPS core. It owns the PC and drives a 1-cycle-latency synchronous instruction ROM. It resolves beq/bne/j/jal/jr next-PC selection and stalls IO-read instructions on a debounced, edge-qualified confirm button. It halts at a configurable address or on a misaligned jr target. It sits between the instruction ROM and the decoder/ALU, and supplies PC+4 to both.

---
 rtl/ifetch_unit_pkg.sv | 15 +
 rtl/ifetch_unit_btn_debounce.sv | 44 ++++
 rtl/ifetch_unit.sv | 120 ++++++++++++
 tb/tb_ifetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared widths and fetch FSM state encoding
package ifetch_unit_pkg;

    localparam int ISA_WIDTH_DEF       = 32;
    localparam int IMEM_ADDR_WIDTH_DEF = 14;
    localparam int J_ADDR_WIDTH_DEF    = 26;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_IO_WAIT    = 2'd1,
        ST_IO_RELEASE = 2'd2,
        ST_HALT       = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_btn_debounce.sv
// rtl/ifetch_unit_btn_debounce.sv - button synchroniser, debounce counter and rise pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] count;
    logic          flip;

    // The level flips on the last of DEBOUNCE_CYCLES consecutive disagreeing samples
    assign flip = (sync_q2 != level) && (count == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            count   <= '0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
            rise    <= flip & sync_q2;
            if (sync_q2 == level) begin
                count <= '0;
            end else if (flip) begin
                count <= '0;
                level <= sync_q2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC owner, next-PC select, IO stall and halt control
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int                   ISA_WIDTH       = ISA_WIDTH_DEF,
    parameter int                   IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
    parameter int                   J_ADDR_WIDTH    = J_ADDR_WIDTH_DEF,
    parameter logic [ISA_WIDTH-1:0] RESET_PC        = '0,
    parameter logic [ISA_WIDTH-1:0] HALT_PC         = 'h3f00,
    parameter int                   DEBOUNCE_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       branch,
    input  logic                       nbranch,
    input  logic                       jmp,
    input  logic                       jal,
    input  logic                       jr,
    input  logic                       zero,
    input  logic [ISA_WIDTH-1:0]       addr_result,
    input  logic [ISA_WIDTH-1:0]       read_data_1,
    input  logic                       io_read,
    input  logic                       confirm_button,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [ISA_WIDTH-1:0]       imem_data,
    output logic [ISA_WIDTH-1:0]       instruction,
    output logic [ISA_WIDTH-1:0]       pc,
    output logic [ISA_WIDTH-1:0]       branch_base_addr,
    output logic [ISA_WIDTH-1:0]       link_addr,
    output logic                       io_wait,
    output logic                       halted,
    output logic                       misalign
);

    fetch_state_t         state_q, state_d;
    logic [ISA_WIDTH-1:0] pc_q, pc_d, pc_plus4, next_pc, jump_target;
    logic                 misalign_q, misalign_d;
    logic                 take_jump, take_branch, take_jr, jr_bad, at_halt;
    logic                 btn_level, btn_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock  (clock),
        .reset  (reset),
        .button (confirm_button),
        .level  (btn_level),
        .rise   (btn_rise)
    );

    assign pc_plus4    = pc_q + ISA_WIDTH'(4);
    assign jump_target = {pc_plus4[ISA_WIDTH-1:J_ADDR_WIDTH+2], imem_data[J_ADDR_WIDTH-1:0], 2'b00};
    assign take_jump   = jmp | jal;
    assign take_branch = (branch & zero) | (nbranch & ~zero);
    assign take_jr     = jr & ~take_jump & ~take_branch;
    assign jr_bad      = take_jr & (read_data_1[1:0] != 2'b00);
    assign at_halt     = (pc_q == HALT_PC);

    always_comb begin
        next_pc = pc_plus4;
        if (take_jump)        next_pc = jump_target;
        else if (take_branch) next_pc = addr_result;
        else if (jr)          next_pc = read_data_1;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_RUN, ST_IO_RELEASE: begin
                if (at_halt) begin
                    state_d = ST_HALT;
                end else if (jr_bad) begin
                    state_d    = ST_HALT;
                    misalign_d = 1'b1;
                end else if (io_read && !take_jump) begin
                    // After a release, a new stall needs the button seen low first
                    if (state_q == ST_RUN || !btn_level) state_d = ST_IO_WAIT;
                end else begin
                    pc_d = next_pc;
                    if (!btn_level) state_d = ST_RUN;
                end
            end
            ST_IO_WAIT: begin
                if (at_halt) begin
                    state_d = ST_HALT;
                end else if (btn_rise) begin
                    pc_d    = next_pc;
                    state_d = ST_IO_RELEASE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Address the ROM with the upcoming PC so its registered output lines up with pc
    assign imem_addr = reset ? RESET_PC[IMEM_ADDR_WIDTH+1:2] : pc_d[IMEM_ADDR_WIDTH+1:2];

    assign instruction      = (reset || state_q == ST_HALT) ? '0 : imem_data;
    assign pc               = pc_q;
    assign branch_base_addr = pc_plus4;
    assign link_addr        = pc_plus4;
    assign io_wait          = (state_q == ST_IO_WAIT);
    assign halted           = (state_q == ST_HALT);
    assign misalign         = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and randomized checks of ifetch_unit against a reference model
module tb_ifetch_unit;

    localparam int          DB       = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] HALT_AT  = 32'h0000_3f00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch = 0, nbranch = 0, jmp = 0, jal = 0, jr = 0, zero = 0;
    logic [31:0] addr_result = '0, read_data_1 = '0;
    logic        io_read = 0, confirm_button = 0;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction, pc, branch_base_addr, link_addr;
    logic        io_wait, halted, misalign;

    logic [31:0] rom [16384];
    int          ctrl_tab [16384];
    int          total = 0;
    int          bad = 0;

    logic [31:0] m_pc;
    bit          m_halted, m_waiting, m_released, m_misalign, m_lvl, m_rise;
    int          m_run;
    bit          rawq [$];

    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= rom[imem_addr];

    ifetch_unit #(
        .ISA_WIDTH(32), .IMEM_ADDR_WIDTH(14), .J_ADDR_WIDTH(26),
        .RESET_PC(RST_PC), .HALT_PC(HALT_AT), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .branch(branch), .nbranch(nbranch),
        .jmp(jmp), .jal(jal), .jr(jr), .zero(zero), .addr_result(addr_result),
        .read_data_1(read_data_1), .io_read(io_read), .confirm_button(confirm_button),
        .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
        .pc(pc), .branch_base_addr(branch_base_addr), .link_addr(link_addr),
        .io_wait(io_wait), .halted(halted), .misalign(misalign)
    );

    // One clock edge: reference model follows the behavioural rules, then outputs settle
    task automatic tick();
        logic [31:0] p4, npc, pcn, w0;
        bit tj, tb, tjr, h, w, r, mis, samp, n_lvl, n_rise;
        int n_run;
        pcn = m_pc; h = m_halted; w = m_waiting; r = m_released; mis = m_misalign;
        n_lvl = m_lvl; n_rise = 1'b0; n_run = m_run;
        if (reset) begin
            pcn = RST_PC; h = 0; w = 0; r = 0; mis = 0; n_lvl = 0; n_run = 0;
            rawq.delete();
        end else begin
            p4  = m_pc + 32'd4;
            w0  = rom[m_pc[15:2]];
            tj  = jmp | jal;
            tb  = (branch & zero) | (nbranch & ~zero);
            tjr = jr & !tj & !tb;
            npc = tj ? {p4[31:28], w0[25:0], 2'b00} : tb ? addr_result : jr ? read_data_1 : p4;
            if (m_halted) begin
            end else if (m_pc == HALT_AT) begin
                h = 1; w = 0; r = 0;
            end else if (m_waiting) begin
                if (m_rise) begin pcn = npc; w = 0; r = 1; end
            end else if (tjr && read_data_1[1:0] != 2'b00) begin
                h = 1; mis = 1; w = 0; r = 0;
            end else if (io_read && !tj) begin
                if (!m_released || !m_lvl) begin w = 1; r = 0; end
            end else begin
                pcn = npc;
                if (!m_lvl) r = 0;
            end
            rawq.push_back(confirm_button);
            samp = (rawq.size() >= 3) ? rawq[rawq.size()-3] : 1'b0;
            if (rawq.size() > 4) void'(rawq.pop_front());
            if (samp != m_lvl) begin
                n_run = n_run + 1;
                if (n_run == DB) begin n_lvl = samp; n_run = 0; n_rise = samp; end
            end else begin
                n_run = 0;
            end
        end
        @(posedge clock);
        m_pc = pcn; m_halted = h; m_waiting = w; m_released = r; m_misalign = mis;
        m_lvl = n_lvl; m_rise = n_rise; m_run = n_run;
        @(negedge clock);
    endtask

    task automatic clear_ctrl();
        branch = 0; nbranch = 0; jmp = 0; jal = 0; jr = 0; zero = 0;
        io_read = 0; addr_result = '0; read_data_1 = '0;
    endtask

    task automatic do_reset();
        clear_ctrl();
        confirm_button = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16384; i++) rom[i] = 32'h0;
        rom[0] = 32'h2008_0005;
        clear_ctrl();
        reset = 1;
        tick(); tick();
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instruction); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
        total++; if ({halted, io_wait, misalign} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {halted, io_wait, misalign}); end
        reset = 0;
        #1;
        total++; if (instruction !== 32'h2008_0005) begin bad++; $display("FAIL first_instr got=%h exp=20080005", instruction); end
        tick();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL pc_after_first got=%h exp=4", pc); end
        total++; if (link_addr !== 32'h8) begin bad++; $display("FAIL link_at_4 got=%h exp=8", link_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        branch = 1; zero = 1; addr_result = 32'h40;
        tick();
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL beq_taken got=%h exp=40", pc); end
        zero = 0; addr_result = 32'h80;
        tick();
        total++; if (pc !== 32'h44) begin bad++; $display("FAIL beq_not_taken got=%h exp=44", pc); end
        branch = 0; nbranch = 1; zero = 0; addr_result = 32'h100;
        tick();
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL bne_taken got=%h exp=100", pc); end
        zero = 1; addr_result = 32'h200;
        tick();
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL bne_not_taken got=%h exp=104", pc); end
    endtask

    task automatic test_jump();
        rom[0] = 32'h0800_0010;
        rom[2] = 32'h0c00_0020;
        do_reset();
        jr = 1; read_data_1 = 32'h1000_0000;
        tick();
        total++; if (pc !== 32'h1000_0000) begin bad++; $display("FAIL jr_aligned got=%h exp=10000000", pc); end
        total++; if (instruction !== 32'h0800_0010) begin bad++; $display("FAIL jr_instr got=%h exp=08000010", instruction); end
        jr = 0; jmp = 1;
        tick();
        total++; if (pc !== 32'h1000_0040) begin bad++; $display("FAIL j_target got=%h exp=10000040", pc); end
        do_reset();
        tick(); tick();
        jal = 1;
        #1;
        total++; if (link_addr !== 32'hC) begin bad++; $display("FAIL jal_link got=%h exp=c", link_addr); end
        tick();
        total++; if (pc !== 32'h80) begin bad++; $display("FAIL jal_target got=%h exp=80", pc); end
    endtask

    task automatic test_io();
        int adv;
        logic [31:0] prev;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL io_setup got=%h exp=20", pc); end
        io_read = 1;
        tick();
        total++; if (io_wait !== 1'b1 || pc !== 32'h20) begin bad++; $display("FAIL io_stall io_wait=%b pc=%h exp=1/20", io_wait, pc); end
        confirm_button = 1;
        for (int i = 0; i < 3; i++) tick();
        confirm_button = 0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (pc !== 32'h20 || io_wait !== 1'b1) begin bad++; $display("FAIL short_pulse pc=%h io_wait=%b exp=20/1", pc, io_wait); end
        adv = 0;
        confirm_button = 1;
        for (int i = 0; i < 10; i++) begin prev = pc; tick(); if (pc !== prev) adv++; end
        total++; if (pc !== 32'h24 || adv != 1) begin bad++; $display("FAIL long_press pc=%h adv=%0d exp=24/1", pc, adv); end
        for (int i = 0; i < 6; i++) tick();
        total++; if (pc !== 32'h24) begin bad++; $display("FAIL held_no_repeat got=%h exp=24", pc); end
        confirm_button = 0;
        for (int i = 0; i < 12; i++) tick();
        total++; if (pc !== 32'h24 || io_wait !== 1'b1) begin bad++; $display("FAIL release_rewait pc=%h io_wait=%b exp=24/1", pc, io_wait); end
        confirm_button = 1;
        for (int i = 0; i < 10; i++) tick();
        total++; if (pc !== 32'h28) begin bad++; $display("FAIL second_press got=%h exp=28", pc); end
        io_read = 0;
    endtask

    task automatic test_misalign();
        do_reset();
        jr = 1; read_data_1 = 32'h0000_0102;
        tick();
        total++; if ({halted, misalign} !== 2'b11) begin bad++; $display("FAIL mis_flags got=%b exp=11", {halted, misalign}); end
        total++; if (pc !== 32'h0 || instruction !== 32'h0) begin bad++; $display("FAIL mis_hold pc=%h instr=%h exp=0/0", pc, instruction); end
        tick(); tick();
        total++; if (pc !== 32'h0 || halted !== 1'b1) begin bad++; $display("FAIL mis_stays pc=%h halted=%b exp=0/1", pc, halted); end
        do_reset();
        total++; if ({halted, misalign, io_wait} !== 3'b000 || pc !== 32'h0) begin bad++; $display("FAIL mis_reset flags=%b pc=%h exp=000/0", {halted, misalign, io_wait}, pc); end
    endtask

    task automatic test_halt_pc();
        int n;
        do_reset();
        n = 0;
        while (pc !== HALT_AT && n < 5000) begin tick(); n++; end
        total++; if (pc !== HALT_AT) begin bad++; $display("FAIL reach_halt_pc got=%h exp=3f00", pc); end
        tick();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_entered got=%b exp=1", halted); end
        for (int i = 0; i < 20; i++) begin
            io_read = 1'($urandom_range(0, 1)); jmp = 1'($urandom_range(0, 1));
            jr = 1'($urandom_range(0, 1)); read_data_1 = $urandom; confirm_button = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (pc !== HALT_AT || halted !== 1'b1 || instruction !== 32'h0) begin
                bad++; $display("FAIL halt_hold cyc=%0d pc=%h halted=%b instr=%h exp=3f00/1/0", i, pc, halted, instruction);
            end
        end
        clear_ctrl();
    endtask

    task automatic test_random();
        int c, btn_left, halt_cnt;
        logic [31:0] exp_instr;
        for (int i = 0; i < 16384; i++) begin
            rom[i] = $urandom;
            c = $urandom_range(0, 19);
            ctrl_tab[i] = (c > 7) ? 0 : c;
        end
        do_reset();
        btn_left = 0; halt_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c = ctrl_tab[m_pc[15:2]];
            clear_ctrl();
            branch = (c == 1); nbranch = (c == 2); jmp = (c == 3) || (c == 7);
            jal = (c == 4); jr = (c == 5); io_read = (c == 6) || (c == 7);
            zero = 1'($urandom_range(0, 1));
            addr_result = $urandom & 32'h0000_3ffc;
            read_data_1 = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_3ffc);
            if (btn_left == 0) begin
                confirm_button = ~confirm_button;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
            reset = (halt_cnt > 4) || ($urandom_range(0, 399) == 0);
            tick();
            exp_instr = (reset || m_halted) ? 32'h0 : rom[m_pc[15:2]];
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc, m_pc); end
            total++; if (instruction !== exp_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", cyc, instruction, exp_instr); end
            total++; if (io_wait !== m_waiting) begin bad++; $display("FAIL rnd_io_wait cyc=%0d got=%b exp=%b", cyc, io_wait, m_waiting); end
            total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", cyc, halted, m_halted); end
            total++; if (misalign !== m_misalign) begin bad++; $display("FAIL rnd_misalign cyc=%0d got=%b exp=%b", cyc, misalign, m_misalign); end
            total++; if (link_addr !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_link cyc=%0d got=%h exp=%h", cyc, link_addr, m_pc + 32'd4); end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_io();
        test_misalign();
        test_halt_pc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
